button_event_queue: RTL and testbench

Collects one-cycle press pulses from the per-button debouncers, arbitrates simultaneous presses, and buffers them as coded events in a small FIFO for the sudoku game controller. It is the consumer side of the debouncer interface: it accepts the `btn_out` pulses and drives the debouncers' `block` input back when it is close to full. Downstream logic pops events through a valid/ready handshake.

---
 rtl/button_event_queue.sv | 132 +++++++++++++
 tb/tb_button_event_queue.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/button_event_queue.sv
// ============================================================================
// Module   : button_event_queue
// Brief    : Arbitrates debounced button pulses into a show-ahead event FIFO
//            with registered back-pressure. Optional macro:
//            BTN_QUEUE_DROP_COUNT_EN adds a saturating coalesced-press counter.
// Revision : 1.0
// ============================================================================
`default_nettype none

module button_event_queue #(
    parameter int NUM_BTNS    = 5,
    parameter int DEPTH       = 4,
    parameter int BLOCK_LEVEL = 3
) (
    input  logic                      clk,
    input  logic                      reset_fixed,
    input  logic [NUM_BTNS-1:0]       btn_pulse,
    output logic                      block,
    output logic                      evt_valid,
    output logic [2:0]                evt_code,
    input  logic                      evt_ready,
    output logic [$clog2(DEPTH):0]    evt_count
`ifdef BTN_QUEUE_DROP_COUNT_EN
    ,
    output logic [7:0]                drop_count
`endif
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_DEPTH       = c_CNT_W'(DEPTH);
    localparam logic [c_CNT_W-1:0] c_BLOCK_LEVEL = c_CNT_W'(BLOCK_LEVEL);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE     = c_CNT_W'(1);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE     = c_PTR_W'(1);

    logic [NUM_BTNS-1:0] r_pending;
    logic [c_PTR_W-1:0]  r_wr_ptr;
    logic [c_PTR_W-1:0]  r_rd_ptr;
    logic [c_CNT_W-1:0]  r_count;
    logic                r_block;
    logic [2:0]          r_mem [DEPTH];

    logic [NUM_BTNS-1:0] w_lowest;
    logic [2:0]          w_lowest_code;
    logic [NUM_BTNS-1:0] w_grant;
    logic                w_push;
    logic                w_pop;
    logic [c_CNT_W-1:0]  w_count_next;

    // Descending scan so the lowest set index is the last (winning) assignment.
    always_comb begin
        w_lowest      = '0;
        w_lowest_code = '0;
        for (int i = NUM_BTNS - 1; i >= 0; i--) begin
            if (r_pending[i]) begin
                w_lowest      = '0;
                w_lowest[i]   = 1'b1;
                w_lowest_code = 3'(i);
            end
        end
    end

    assign w_pop   = (r_count != '0) && evt_ready;
    assign w_push  = (r_pending != '0) && ((r_count < c_DEPTH) || w_pop);
    assign w_grant = w_push ? w_lowest : '0;

    always_comb begin
        w_count_next = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + c_CNT_ONE;
            2'b01:   w_count_next = r_count - c_CNT_ONE;
            default: w_count_next = r_count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset_fixed) begin
            r_pending <= '0;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_block   <= 1'b0;
        end else begin
            r_pending <= (r_pending & ~w_grant) | btn_pulse;
            if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            r_count   <= w_count_next;
            r_block   <= (w_count_next >= c_BLOCK_LEVEL);
        end
    end

    // Storage is intentionally left out of reset; the count gates its visibility.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= w_lowest_code;
    end

    assign block     = r_block;
    assign evt_valid = (r_count != '0);
    assign evt_code  = r_mem[r_rd_ptr];
    assign evt_count = r_count;

`ifdef BTN_QUEUE_DROP_COUNT_EN
    logic [NUM_BTNS-1:0] w_drop_bits;
    logic [3:0]          w_drop_inc;
    logic [8:0]          w_drop_sum;
    logic [7:0]          r_drop_count;

    assign w_drop_bits = btn_pulse & r_pending & ~w_grant;

    always_comb begin
        w_drop_inc = '0;
        for (int i = 0; i < NUM_BTNS; i++) begin
            w_drop_inc = w_drop_inc + {3'b000, w_drop_bits[i]};
        end
    end

    assign w_drop_sum = {1'b0, r_drop_count} + {5'b00000, w_drop_inc};

    always_ff @(posedge clk) begin
        if (reset_fixed) begin
            r_drop_count <= '0;
        end else begin
            r_drop_count <= w_drop_sum[8] ? 8'hFF : w_drop_sum[7:0];
        end
    end

    assign drop_count = r_drop_count;
`endif

endmodule

`default_nettype wire

// File: tb/tb_button_event_queue.sv
// ============================================================================
// Module   : tb_button_event_queue
// Brief    : Directed table-driven bench for button_event_queue.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_button_event_queue;

    logic       clk;
    logic       reset_fixed;
    logic [4:0] btn_pulse;
    logic       block;
    logic       evt_valid;
    logic [2:0] evt_code;
    logic       evt_ready;
    logic [2:0] evt_count;
    logic [7:0] drop_count;

    int checks;
    int errors;

    button_event_queue #(
        .NUM_BTNS    (5),
        .DEPTH       (4),
        .BLOCK_LEVEL (3)
    ) dut (
        .clk         (clk),
        .reset_fixed (reset_fixed),
        .btn_pulse   (btn_pulse),
        .block       (block),
        .evt_valid   (evt_valid),
        .evt_code    (evt_code),
        .evt_ready   (evt_ready),
        .evt_count   (evt_count)
`ifdef BTN_QUEUE_DROP_COUNT_EN
        ,
        .drop_count  (drop_count)
`endif
    );

`ifndef BTN_QUEUE_DROP_COUNT_EN
    assign drop_count = 8'd0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [4:0] pulse;
        logic       rdy;
        logic       valid;
        logic [2:0] code;
        logic [2:0] count;
        logic       blk;
        logic [7:0] drop;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst, input logic [4:0] pulse, input logic rdy,
                       input logic valid, input logic [2:0] code,
                       input logic [2:0] count, input logic blk, input logic [7:0] drop);
        vec_t v;
        v.rst = rst; v.pulse = pulse; v.rdy = rdy; v.valid = valid;
        v.code = code; v.count = count; v.blk = blk; v.drop = drop;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic cycle(input logic rst, input logic [4:0] pulse, input logic rdy);
        @(negedge clk);
        reset_fixed = rst;
        btn_pulse   = pulse;
        evt_ready   = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic check_outputs(input int idx, input logic valid, input logic [2:0] code,
                                 input logic [2:0] count, input logic blk,
                                 input logic [7:0] drop);
        check("evt_valid", idx, 32'(evt_valid), 32'(valid));
        check("evt_count", idx, 32'(evt_count), 32'(count));
        check("block", idx, 32'(block), 32'(blk));
        if (valid) check("evt_code", idx, 32'(evt_code), 32'(code));
`ifdef BTN_QUEUE_DROP_COUNT_EN
        check("drop_count", idx, 32'(drop_count), 32'(drop));
`endif
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        reset_fixed = 1'b1;
        btn_pulse   = '0;
        evt_ready   = 1'b0;

        //   rst  pulse     rdy  valid code count blk drop
        add(1'b1, 5'b00000, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 8'd0); // 0 reset
        add(1'b0, 5'b00100, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 8'd0); // 1 single press
        add(1'b0, 5'b00000, 1'b0, 1'b1, 3'd2, 3'd1, 1'b0, 8'd0); // 2
        add(1'b0, 5'b00000, 1'b1, 1'b0, 3'd0, 3'd0, 1'b0, 8'd0); // 3 pop
        add(1'b0, 5'b10110, 1'b1, 1'b0, 3'd0, 3'd0, 1'b0, 8'd0); // 4 simultaneous
        add(1'b0, 5'b00000, 1'b1, 1'b1, 3'd1, 3'd1, 1'b0, 8'd0); // 5
        add(1'b0, 5'b00000, 1'b1, 1'b1, 3'd2, 3'd1, 1'b0, 8'd0); // 6
        add(1'b0, 5'b00000, 1'b1, 1'b1, 3'd4, 3'd1, 1'b0, 8'd0); // 7
        add(1'b0, 5'b00000, 1'b1, 1'b0, 3'd0, 3'd0, 1'b0, 8'd0); // 8
        add(1'b0, 5'b00001, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 8'd0); // 9 fill
        add(1'b0, 5'b00010, 1'b0, 1'b1, 3'd0, 3'd1, 1'b0, 8'd0); // 10
        add(1'b0, 5'b00100, 1'b0, 1'b1, 3'd0, 3'd2, 1'b0, 8'd0); // 11
        add(1'b0, 5'b01000, 1'b0, 1'b1, 3'd0, 3'd3, 1'b1, 8'd0); // 12 block rises
        add(1'b0, 5'b00000, 1'b0, 1'b1, 3'd0, 3'd4, 1'b1, 8'd0); // 13 full
        add(1'b0, 5'b10000, 1'b0, 1'b1, 3'd0, 3'd4, 1'b1, 8'd0); // 14
        add(1'b0, 5'b00000, 1'b0, 1'b1, 3'd0, 3'd4, 1'b1, 8'd0); // 15 held
        add(1'b0, 5'b00001, 1'b0, 1'b1, 3'd0, 3'd4, 1'b1, 8'd0); // 16 coalesce
        add(1'b0, 5'b00001, 1'b0, 1'b1, 3'd0, 3'd4, 1'b1, 8'd1); // 17 dropped
        add(1'b0, 5'b00000, 1'b1, 1'b1, 3'd1, 3'd4, 1'b1, 8'd1); // 18 push+pop
        add(1'b0, 5'b00000, 1'b1, 1'b1, 3'd2, 3'd4, 1'b1, 8'd1); // 19
        add(1'b0, 5'b00000, 1'b1, 1'b1, 3'd3, 3'd3, 1'b1, 8'd1); // 20 drain
        add(1'b0, 5'b00000, 1'b1, 1'b1, 3'd0, 3'd2, 1'b0, 8'd1); // 21
        add(1'b0, 5'b00000, 1'b1, 1'b1, 3'd4, 3'd1, 1'b0, 8'd1); // 22
        add(1'b0, 5'b00000, 1'b1, 1'b0, 3'd0, 3'd0, 1'b0, 8'd1); // 23
        add(1'b0, 5'b00000, 1'b1, 1'b0, 3'd0, 3'd0, 1'b0, 8'd1); // 24 no underflow
        add(1'b0, 5'b00000, 1'b1, 1'b0, 3'd0, 3'd0, 1'b0, 8'd1); // 25
        add(1'b0, 5'b00000, 1'b1, 1'b0, 3'd0, 3'd0, 1'b0, 8'd1); // 26
        add(1'b0, 5'b00111, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 8'd1); // 27 mid reset
        add(1'b0, 5'b00000, 1'b0, 1'b1, 3'd0, 3'd1, 1'b0, 8'd1); // 28
        add(1'b0, 5'b00000, 1'b0, 1'b1, 3'd0, 3'd2, 1'b0, 8'd1); // 29
        add(1'b0, 5'b00010, 1'b0, 1'b1, 3'd0, 3'd3, 1'b1, 8'd1); // 30
        add(1'b1, 5'b00000, 1'b1, 1'b0, 3'd0, 3'd0, 1'b0, 8'd0); // 31 reset
        add(1'b0, 5'b00000, 1'b1, 1'b0, 3'd0, 3'd0, 1'b0, 8'd0); // 32 no stale
        add(1'b0, 5'b00000, 1'b1, 1'b0, 3'd0, 3'd0, 1'b0, 8'd0); // 33

        for (int i = 0; i < vecs.size(); i++) begin
            cycle(vecs[i].rst, vecs[i].pulse, vecs[i].rdy);
            check_outputs(i, vecs[i].valid, vecs[i].code, vecs[i].count,
                          vecs[i].blk, vecs[i].drop);
        end

        // A pulse landing on the bit being granted re-arms it: two events, no drop.
        cycle(1'b0, 5'b00001, 1'b0);
        check_outputs(100, 1'b0, 3'd0, 3'd0, 1'b0, 8'd0);
        cycle(1'b0, 5'b00001, 1'b0);
        check_outputs(101, 1'b1, 3'd0, 3'd1, 1'b0, 8'd0);
        cycle(1'b0, 5'b00000, 1'b0);
        check_outputs(102, 1'b1, 3'd0, 3'd2, 1'b0, 8'd0);
        cycle(1'b0, 5'b00000, 1'b1);
        check_outputs(103, 1'b1, 3'd0, 3'd1, 1'b0, 8'd0);
        cycle(1'b0, 5'b00000, 1'b1);
        check_outputs(104, 1'b0, 3'd0, 3'd0, 1'b0, 8'd0);

        // Bounded wait on pulse-to-valid latency.
        begin
            int lat;
            lat = 0;
            cycle(1'b0, 5'b01000, 1'b0);
            lat = 1;
            while (!evt_valid && lat < 6) begin
                cycle(1'b0, 5'b00000, 1'b0);
                lat++;
            end
            check("latency", 200, 32'(lat), 32'd2);
            check("latency_code", 200, 32'(evt_code), 32'd3);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
